dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/arb_sat_counter.sv | 42 ++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - ownerT           : tag recording who issued the read in flight
//   - DEF_STARVE_LIMIT : default debug starvation threshold (cycles)
//   - DEF_DBG_MAX_BURST: default cap on consecutive debug grants vs. the core
//   - cntWidth()       : bit width needed to count 0..maxVal inclusive
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int DEF_STARVE_LIMIT  = 8;
    localparam int DEF_DBG_MAX_BURST = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_DBG  = 2'd2
    } ownerT;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// ---------------------------------------------------------------------------
// arb_sat_counter
// Saturating up-counter with synchronous clear; clear beats increment.
// Only the "at limit" flag is exported because the arbiter only ever asks
// whether the count has reached its limit.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset (count -> 0)
//   inc   : count up by one, holding at MAX_COUNT
//   clr   : return to zero on the next edge
//   atMax : count == MAX_COUNT
// ---------------------------------------------------------------------------
module arb_sat_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic atMax
);

    localparam int             W       = cntWidth(MAX_COUNT);
    localparam logic [W-1:0]   MAX_VAL = W'(MAX_COUNT);

    logic [W-1:0] cntReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntReg <= '0;
        end else if (clr) begin
            cntReg <= '0;
        end else if (inc && (cntReg != MAX_VAL)) begin
            cntReg <= cntReg + 1'b1;
        end
    end

    assign atMax = (cntReg == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter (pipeline MEM stage vs. debug/loader) in front of a
// single-port data memory with one-cycle read latency. The core wins by
// default; debug gets idle cycles, is forced in after STARVE_LIMIT ungranted
// cycles, and is capped at DBG_MAX_BURST consecutive grants while the core
// is waiting. Grant and memory command are combinational; read returns are
// routed by an owner tag registered at the grant edge.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   core_req/we/addr/wdata         : core access request
//   core_stall                     : core request not granted this cycle
//   core_rdata, core_rvalid        : core load return
//   dbg_req/we/addr/wdata          : debug access request
//   dbg_gnt                        : debug request accepted this cycle
//   dbg_rdata, dbg_rvalid          : debug load return
//   mem_en/we/addr/wdata           : memory command
//   mem_rdata                      : memory read data (one cycle after read)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT,
    parameter int DBG_MAX_BURST = DEF_DBG_MAX_BURST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic  starveAtMax;
    logic  burstAtMax;
    logic  coreGnt;
    logic  dbgGnt;
    ownerT ownerReg;
    ownerT ownerNext;
    logic [31:0] coreRdataReg;
    logic [31:0] dbgRdataReg;

    // Grants are gated by rst so nothing reaches memory while reset is held,
    // even though the request inputs may still be active.
    always_comb begin
        dbgGnt  = 1'b0;
        coreGnt = 1'b0;
        if (rst) begin
            // The burst cap overrides starvation forcing.
            if (dbg_req && !(burstAtMax && core_req) && (!core_req || starveAtMax)) begin
                dbgGnt = 1'b1;
            end
            coreGnt = core_req && !dbgGnt;
        end
    end

    assign dbg_gnt    = dbgGnt;
    assign core_stall = rst && core_req && !coreGnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbgGnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (coreGnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    arb_sat_counter #(.MAX_COUNT(STARVE_LIMIT)) starveCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (dbg_req && !dbgGnt),
        .clr   (!dbg_req || dbgGnt),
        .atMax (starveAtMax)
    );

    arb_sat_counter #(.MAX_COUNT(DBG_MAX_BURST)) burstCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (dbgGnt),
        .clr   (coreGnt || !dbg_req),
        .atMax (burstAtMax)
    );

    // Only reads get an owner; writes leave the tag at NONE so no rvalid follows.
    always_comb begin
        ownerNext = OWNER_NONE;
        if (dbgGnt && !dbg_we) begin
            ownerNext = OWNER_DBG;
        end else if (coreGnt && !core_we) begin
            ownerNext = OWNER_CORE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ownerReg     <= OWNER_NONE;
            coreRdataReg <= '0;
            dbgRdataReg  <= '0;
        end else begin
            ownerReg <= ownerNext;
            if (ownerReg == OWNER_CORE) begin
                coreRdataReg <= mem_rdata;
            end
            if (ownerReg == OWNER_DBG) begin
                dbgRdataReg <= mem_rdata;
            end
        end
    end

    // Return data passes straight through in the valid cycle and is held after.
    assign core_rvalid = (ownerReg == OWNER_CORE);
    assign dbg_rvalid  = (ownerReg == OWNER_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : coreRdataReg;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : dbgRdataReg;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int SL = 8;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        coreReq, coreWe, dbgReq, dbgWe;
    logic [31:0] coreAddr, coreWdata, dbgAddr, dbgWdata, memRdata;
    logic        coreStall, coreRvalid, dbgGnt, dbgRvalid, memEn, memWe;
    logic [31:0] coreRdata, dbgRdata, memAddr, memWdata;

    dmem_arbiter #(.STARVE_LIMIT(SL), .DBG_MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (coreReq),
        .core_we     (coreWe),
        .core_addr   (coreAddr),
        .core_wdata  (coreWdata),
        .core_stall  (coreStall),
        .core_rdata  (coreRdata),
        .core_rvalid (coreRvalid),
        .dbg_req     (dbgReq),
        .dbg_we      (dbgWe),
        .dbg_addr    (dbgAddr),
        .dbg_wdata   (dbgWdata),
        .dbg_gnt     (dbgGnt),
        .dbg_rdata   (dbgRdata),
        .dbg_rvalid  (dbgRvalid),
        .mem_en      (memEn),
        .mem_we      (memWe),
        .mem_addr    (memAddr),
        .mem_wdata   (memWdata),
        .mem_rdata   (memRdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain counts and a pending-read owner (0 none, 1 core, 2 dbg).
    int          mStarve = 0;
    int          mBurst  = 0;
    int          mPend   = 0;
    logic [31:0] mCoreHold = '0;
    logic [31:0] mDbgHold  = '0;

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwdata;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata, mrdata;
        logic        eStall, eDgnt, eEn, eWe;
        logic [31:0] eAddr, eWdata;
        logic        eCrv;
        logic [31:0] eCrdata;
        logic        eDrv;
        logic [31:0] eDrdata;
    } vecT;

    vecT tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIdle();
        coreReq = 0; coreWe = 0; coreAddr = '0; coreWdata = '0;
        dbgReq  = 0; dbgWe  = 0; dbgAddr  = '0; dbgWdata  = '0;
        memRdata = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle, compare every output against the model, then advance the model.
    task automatic checkCycle(input string tag);
        logic        eDg, eCg, eStall, eEn, eWe, eCrv, eDrv, forceDbg, cap;
        logic [31:0] eAddr, eWd, eCrd, eDrd;
        int          pendNext;
        #3;
        eDg = 0; eCg = 0; eStall = 0; eEn = 0; eWe = 0; eAddr = '0; eWd = '0;
        eCrv = 0; eDrv = 0; eCrd = '0; eDrd = '0;
        if (!rst) begin
            mStarve = 0; mBurst = 0; mPend = 0; mCoreHold = '0; mDbgHold = '0;
        end else begin
            forceDbg = dbgReq && (mStarve >= SL);
            cap      = coreReq && (mBurst >= MB);
            eDg      = dbgReq && !cap && (!coreReq || forceDbg);
            eCg      = coreReq && !eDg;
            eStall   = coreReq && !eCg;
            if (eDg) begin
                eEn = 1; eWe = dbgWe; eAddr = dbgAddr; eWd = dbgWdata;
            end else if (eCg) begin
                eEn = 1; eWe = coreWe; eAddr = coreAddr; eWd = coreWdata;
            end
            eCrv = (mPend == 1);
            eDrv = (mPend == 2);
            eCrd = eCrv ? memRdata : mCoreHold;
            eDrd = eDrv ? memRdata : mDbgHold;
        end
        chk({tag, "_stall"},  coreStall,  eStall);
        chk({tag, "_dgnt"},   dbgGnt,     eDg);
        chk({tag, "_memen"},  memEn,      eEn);
        chk({tag, "_memwe"},  memWe,      eWe);
        chk({tag, "_maddr"},  memAddr,    eAddr);
        chk({tag, "_mwdata"}, memWdata,   eWd);
        chk({tag, "_crv"},    coreRvalid, eCrv);
        chk({tag, "_crdata"}, coreRdata,  eCrd);
        chk({tag, "_drv"},    dbgRvalid,  eDrv);
        chk({tag, "_drdata"}, dbgRdata,   eDrd);
        $display("%s t=%0t rst=%b req c/d=%b/%b gnt c/d=%b/%b en=%b we=%b addr=%h rv c/d=%b/%b",
                 tag, $time, rst, coreReq, dbgReq, !coreStall && coreReq, dbgGnt,
                 memEn, memWe, memAddr, coreRvalid, dbgRvalid);
        if (rst) begin
            pendNext = (eDg && !dbgWe) ? 2 : ((eCg && !coreWe) ? 1 : 0);
            if (mPend == 1) mCoreHold = memRdata;
            if (mPend == 2) mDbgHold  = memRdata;
            mPend   = pendNext;
            mStarve = (!dbgReq || eDg) ? 0 : ((mStarve < SL) ? mStarve + 1 : SL);
            mBurst  = (!dbgReq || eCg) ? 0 : (eDg ? ((mBurst < MB) ? mBurst + 1 : MB) : mBurst);
        end
    endtask

    // Hold reset for two cycles with live requests (which must be ignored), then release.
    task automatic doReset();
        rst = 0;
        setIdle();
        coreReq = 1; dbgReq = 1; coreAddr = 32'h4; dbgAddr = 32'h8;
        for (int i = 0; i < 2; i++) begin
            checkCycle("reset");
            chk("reset_stall", coreStall, 1'b0);
            chk("reset_memen", memEn, 1'b0);
            nextCycle();
        end
        setIdle();
        rst = 1;
    endtask

    initial begin
        setIdle();
        #1;
        doReset();

        // ---- directed table: core read, held rdata, debug write then core read ----
        //            creq cwe caddr      cwdata     dreq dwe daddr      dwdata     mrdata        stall dg en we addr       wdata      crv crdata        drv drdata
        tbl[0] = '{1'b1,1'b0,32'h10,    32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'h0,        1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,    1'b0,32'h0,        1'b0,32'h0};
        tbl[1] = '{1'b0,1'b0,32'h0,     32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b1,32'hDEADBEEF, 1'b0,32'h0};
        tbl[2] = '{1'b0,1'b0,32'h0,     32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'h12345678, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b0,32'hDEADBEEF, 1'b0,32'h0};
        tbl[3] = '{1'b0,1'b0,32'h0,     32'h0,     1'b1,1'b1,32'h20,    32'h55AA,  32'h0,        1'b0,1'b1,1'b1,1'b1,32'h20,32'h55AA, 1'b0,32'hDEADBEEF, 1'b0,32'h0};
        tbl[4] = '{1'b1,1'b0,32'h20,    32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'h0,        1'b0,1'b0,1'b1,1'b0,32'h20,32'h0,    1'b0,32'hDEADBEEF, 1'b0,32'h0};
        tbl[5] = '{1'b0,1'b0,32'h0,     32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'h55AA,     1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b1,32'h55AA,     1'b0,32'h0};
        tbl[6] = '{1'b1,1'b1,32'h44,    32'h99,    1'b1,1'b0,32'h30,    32'h0,     32'h0,        1'b0,1'b0,1'b1,1'b1,32'h44,32'h99,   1'b0,32'h55AA,     1'b0,32'h0};
        tbl[7] = '{1'b0,1'b0,32'h0,     32'h0,     1'b1,1'b0,32'h30,    32'h0,     32'h0,        1'b0,1'b1,1'b1,1'b0,32'h30,32'h0,    1'b0,32'h55AA,     1'b0,32'h0};
        tbl[8] = '{1'b0,1'b0,32'h0,     32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b0,32'h55AA,     1'b1,32'hCAFEF00D};
        tbl[9] = '{1'b0,1'b0,32'h0,     32'h0,     1'b0,1'b0,32'h0,     32'h0,     32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0,    1'b0,32'h55AA,     1'b0,32'hCAFEF00D};

        for (int i = 0; i < 10; i++) begin
            coreReq = tbl[i].creq; coreWe = tbl[i].cwe; coreAddr = tbl[i].caddr; coreWdata = tbl[i].cwdata;
            dbgReq  = tbl[i].dreq; dbgWe  = tbl[i].dwe; dbgAddr  = tbl[i].daddr; dbgWdata  = tbl[i].dwdata;
            memRdata = tbl[i].mrdata;
            checkCycle("table");
            chk("tbl_stall",  coreStall,  tbl[i].eStall);
            chk("tbl_dgnt",   dbgGnt,     tbl[i].eDgnt);
            chk("tbl_memen",  memEn,      tbl[i].eEn);
            chk("tbl_memwe",  memWe,      tbl[i].eWe);
            chk("tbl_maddr",  memAddr,    tbl[i].eAddr);
            chk("tbl_mwdata", memWdata,   tbl[i].eWdata);
            chk("tbl_crv",    coreRvalid, tbl[i].eCrv);
            chk("tbl_crdata", coreRdata,  tbl[i].eCrdata);
            chk("tbl_drv",    dbgRvalid,  tbl[i].eDrv);
            chk("tbl_drdata", dbgRdata,   tbl[i].eDrdata);
            nextCycle();
        end

        // ---- collision: debug forced in after exactly STARVE_LIMIT ungranted cycles ----
        doReset();
        coreReq = 1; coreAddr = 32'h100; dbgReq = 1; dbgAddr = 32'h200;
        for (int c = 0; c < 10; c++) begin
            memRdata = $urandom;
            checkCycle("collide");
            chk("coll_dgnt",  dbgGnt,    (c == SL));
            chk("coll_stall", coreStall, (c == SL));
            nextCycle();
        end

        // ---- debug burst while core idle, then core wins once the cap is reached ----
        doReset();
        dbgReq = 1;
        for (int c = 0; c < 8; c++) begin
            coreReq  = (c >= 6);
            coreAddr = 32'h300;
            dbgAddr  = 32'h400 + 32'(c * 4);
            memRdata = $urandom;
            checkCycle("burst");
            chk("burst_dgnt",  dbgGnt,    (c < 6));
            chk("burst_stall", coreStall, 1'b0);
            nextCycle();
        end

        // ---- reset right after a debug read grant: the return must be dropped ----
        doReset();
        dbgReq = 1; dbgWe = 0; dbgAddr = 32'h40;
        checkCycle("rstrd");
        chk("rstrd_dgnt", dbgGnt, 1'b1);
        nextCycle();
        rst = 0;
        setIdle();
        memRdata = 32'hA5A5A5A5;
        checkCycle("rstrd");
        chk("rstrd_drv_in", dbgRvalid, 1'b0);
        chk("rstrd_drd_in", dbgRdata,  32'h0);
        nextCycle();
        rst = 1;
        memRdata = 32'h5A5A5A5A;
        checkCycle("rstrd");
        chk("rstrd_drv_after", dbgRvalid, 1'b0);
        chk("rstrd_en_after",  memEn,     1'b0);
        nextCycle();

        // ---- randomized traffic with occasional reset pulses ----
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 49) != 0);
            coreReq   = ($urandom_range(0, 3) != 0);
            coreWe    = $urandom_range(0, 1);
            coreAddr  = $urandom;
            coreWdata = $urandom;
            dbgReq    = ($urandom_range(0, 7) != 0);
            dbgWe     = $urandom_range(0, 1);
            dbgAddr   = $urandom;
            dbgWdata  = $urandom;
            memRdata  = $urandom;
            checkCycle("rand");
            nextCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
